// File: rtl/auth_pkg.sv
// Shared definitions for the authentication path: mode encoding and datapath widths.
package auth_pkg;

    // Default width of the shared session/lockout counter.
    localparam int unsigned CNT_W  = 16;
    // Width of the consecutive-failure count.
    localparam int unsigned FAIL_W = 2;

    // Encoding driven onto Authentication.mode; Identification/Password decode the same values.
    typedef enum logic [1:0] {
        MODE_ID      = 2'b00,
        MODE_PW      = 2'b01,
        MODE_SESSION = 2'b10,
        MODE_LOCKED  = 2'b11
    } mode_e;

endpackage

// File: rtl/cycle_counter.sv
// Clearable up-counter with a terminal-count compare against a runtime limit.
module cycle_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_count,
    output logic         o_match
);

    logic [W-1:0] r_count;

    // Count up while enabled; clear wins; never wrap past all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_match = (r_count == i_limit);

endmodule

// File: rtl/auth_session_ctrl.sv
// Session controller in front of Authentication: sequences ID, PW, SESSION and LOCKED,
// and generates the timeout pulse for inactivity, session expiry and lockout entry.
module auth_session_ctrl
    import auth_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned SESSION_CYCLES = 5000,
    parameter int unsigned RESULT_WAIT    = 4,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LOCK_CYCLES    = 2000,
    parameter int unsigned CNT_W          = auth_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BtnPulse,
    input  logic              CheckPassword,
    input  logic              LoggedIn,
    input  logic              Logout,
    output logic [1:0]        mode,
    output logic              timeout,
    output logic              Locked,
    output logic [FAIL_W-1:0] FailCount
);

    // Terminal counts: the counter reads N-1 on the Nth idle cycle after a clear.
    localparam logic [CNT_W-1:0] LIM_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_SESSION = CNT_W'(SESSION_CYCLES - 1);
    localparam logic [CNT_W-1:0] LIM_RESULT  = CNT_W'(RESULT_WAIT - 1);
    localparam logic [CNT_W-1:0] LIM_LOCK    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_FAIL);

    mode_e             r_mode;
    logic              r_entry_active;
    logic              r_attempt_pending;
    logic              r_timeout;
    logic              r_locked;
    logic [FAIL_W-1:0] r_fail_count;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_limit;
    logic              w_match;
    logic              w_run;
    logic              w_cnt_en;
    logic              w_cnt_clr;

    logic              w_id_check, w_id_btn, w_id_to;
    logic              w_pw_login, w_pw_btn, w_pw_fail, w_pw_to;
    logic              w_ss_logout, w_ss_drop, w_ss_btn, w_ss_to;
    logic              w_lk_done;
    logic [FAIL_W-1:0] w_fail_inc;
    logic              w_fail_lock;

    // Select the terminal count and run condition for the current mode.
    always_comb begin
        w_limit = LIM_TIMEOUT;
        w_run   = 1'b1;
        unique case (r_mode)
            MODE_ID: begin
                w_limit = LIM_TIMEOUT;
                w_run   = r_entry_active;
            end
            MODE_PW:      w_limit = r_attempt_pending ? LIM_RESULT : LIM_TIMEOUT;
            MODE_SESSION: w_limit = LIM_SESSION;
            MODE_LOCKED:  w_limit = LIM_LOCK;
        endcase
    end

    // Hold at the terminal count so the counter never runs past its limit.
    assign w_cnt_en = w_run && (w_count < w_limit);

    // Decode this cycle's event in priority order per mode; each event restarts the counter.
    always_comb begin
        w_id_check  = (r_mode == MODE_ID) && CheckPassword;
        w_id_btn    = (r_mode == MODE_ID) && !CheckPassword && BtnPulse;
        w_id_to     = (r_mode == MODE_ID) && !CheckPassword && !BtnPulse
                      && r_entry_active && w_match;

        w_pw_login  = (r_mode == MODE_PW) && LoggedIn;
        w_pw_btn    = (r_mode == MODE_PW) && !LoggedIn && BtnPulse;
        w_pw_fail   = (r_mode == MODE_PW) && !LoggedIn && !BtnPulse
                      && r_attempt_pending && w_match;
        w_pw_to     = (r_mode == MODE_PW) && !LoggedIn && !BtnPulse
                      && !r_attempt_pending && w_match;

        // Logout wins over expiry so a coincident timeout yields a single pulse.
        w_ss_logout = (r_mode == MODE_SESSION) && Logout;
        w_ss_drop   = (r_mode == MODE_SESSION) && !Logout && !LoggedIn;
        w_ss_btn    = (r_mode == MODE_SESSION) && !Logout && LoggedIn && BtnPulse;
        w_ss_to     = (r_mode == MODE_SESSION) && !Logout && LoggedIn && !BtnPulse && w_match;

        w_lk_done   = (r_mode == MODE_LOCKED) && w_match;

        w_cnt_clr   = w_id_check | w_id_btn | w_id_to
                    | w_pw_login | w_pw_btn | w_pw_fail | w_pw_to
                    | w_ss_logout | w_ss_drop | w_ss_btn | w_ss_to
                    | w_lk_done;
    end

    // Failure count after one more rejected attempt, saturating at the limit.
    always_comb begin
        w_fail_inc  = (r_fail_count < FAIL_MAX) ? r_fail_count + 1'b1 : r_fail_count;
        w_fail_lock = (w_fail_inc == FAIL_MAX);
    end

    cycle_counter #(
        .W (CNT_W)
    ) u_cycle_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_limit (w_limit),
        .o_count (w_count),
        .o_match (w_match)
    );

    // Session FSM with registered mode, timeout pulse, lock flag and failure count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode            <= MODE_ID;
            r_entry_active    <= 1'b0;
            r_attempt_pending <= 1'b0;
            r_timeout         <= 1'b0;
            r_locked          <= 1'b0;
            r_fail_count      <= '0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_mode)
                MODE_ID: begin
                    if (w_id_check) begin
                        r_mode         <= MODE_PW;
                        r_entry_active <= 1'b0;
                    end else if (w_id_btn) begin
                        r_entry_active <= 1'b1;
                    end else if (w_id_to) begin
                        r_timeout      <= 1'b1;
                        r_entry_active <= 1'b0;
                    end
                end
                MODE_PW: begin
                    if (w_pw_login) begin
                        r_mode            <= MODE_SESSION;
                        r_fail_count      <= '0;
                        r_attempt_pending <= 1'b0;
                    end else if (w_pw_btn) begin
                        r_attempt_pending <= 1'b1;
                    end else if (w_pw_fail) begin
                        r_attempt_pending <= 1'b0;
                        r_fail_count      <= w_fail_inc;
                        if (w_fail_lock) begin
                            r_mode    <= MODE_LOCKED;
                            r_locked  <= 1'b1;
                            r_timeout <= 1'b1;
                        end
                    end else if (w_pw_to) begin
                        // Attempts already made survive an inactivity timeout.
                        r_mode    <= MODE_ID;
                        r_timeout <= 1'b1;
                    end
                end
                MODE_SESSION: begin
                    if (w_ss_logout || w_ss_to) begin
                        r_mode    <= MODE_ID;
                        r_timeout <= 1'b1;
                    end else if (w_ss_drop) begin
                        r_mode <= MODE_ID;
                    end
                end
                MODE_LOCKED: begin
                    if (w_lk_done) begin
                        r_mode       <= MODE_ID;
                        r_locked     <= 1'b0;
                        r_fail_count <= '0;
                    end
                end
            endcase
        end
    end

    assign mode      = r_mode;
    assign timeout   = r_timeout;
    assign Locked    = r_locked;
    assign FailCount = r_fail_count;

endmodule

// File: tb/tb_auth_session_ctrl.sv
// Directed bench for auth_session_ctrl: per-cycle check against a behavioural model,
// plus literal expectations at the points the scenarios call out.
module tb_auth_session_ctrl;

    localparam int T  = 10;
    localparam int S  = 20;
    localparam int RW = 4;
    localparam int MF = 3;
    localparam int L  = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       BtnPulse, CheckPassword, LoggedIn, Logout;
    logic [1:0] mode;
    logic       timeout, Locked;
    logic [1:0] FailCount;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state: mode number, pending pulse, failures, idle cycles since last event.
    int m_mode, m_to, m_fail, m_idle;
    bit m_entry, m_pend;

    auth_session_ctrl #(
        .TIMEOUT_CYCLES (T),
        .SESSION_CYCLES (S),
        .RESULT_WAIT    (RW),
        .MAX_FAIL       (MF),
        .LOCK_CYCLES    (L),
        .CNT_W          (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .BtnPulse      (BtnPulse),
        .CheckPassword (CheckPassword),
        .LoggedIn      (LoggedIn),
        .Logout        (Logout),
        .mode          (mode),
        .timeout       (timeout),
        .Locked        (Locked),
        .FailCount     (FailCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock: an event resets the idle count, otherwise the
    // Nth idle cycle of a window triggers that window's expiry.
    task automatic model_step();
        m_to = 0;
        if (rst) begin
            m_mode = 0; m_fail = 0; m_entry = 0; m_pend = 0; m_idle = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (CheckPassword) begin
                        m_mode = 1; m_entry = 0; m_idle = 0;
                    end else if (BtnPulse) begin
                        m_entry = 1; m_idle = 0;
                    end else if (m_entry) begin
                        m_idle++;
                        if (m_idle == T) begin m_to = 1; m_entry = 0; m_idle = 0; end
                    end
                end
                1: begin
                    if (LoggedIn) begin
                        m_mode = 2; m_fail = 0; m_pend = 0; m_idle = 0;
                    end else if (BtnPulse) begin
                        m_pend = 1; m_idle = 0;
                    end else begin
                        m_idle++;
                        if (m_pend && m_idle == RW) begin
                            m_pend = 0; m_idle = 0;
                            if (m_fail < MF) m_fail++;
                            if (m_fail == MF) begin m_mode = 3; m_to = 1; end
                        end else if (!m_pend && m_idle == T) begin
                            m_mode = 0; m_to = 1; m_idle = 0;
                        end
                    end
                end
                2: begin
                    if (Logout) begin
                        m_mode = 0; m_to = 1; m_idle = 0;
                    end else if (!LoggedIn) begin
                        m_mode = 0; m_idle = 0;
                    end else if (BtnPulse) begin
                        m_idle = 0;
                    end else begin
                        m_idle++;
                        if (m_idle == S) begin m_mode = 0; m_to = 1; m_idle = 0; end
                    end
                end
                default: begin
                    m_idle++;
                    if (m_idle == L) begin m_mode = 0; m_fail = 0; m_idle = 0; end
                end
            endcase
        end
    endtask

    always @(posedge clk) model_step();

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_mode", int'(mode), m_mode);
            check("model_timeout", int'(timeout), m_to);
            check("model_locked", int'(Locked), (m_mode == 3) ? 1 : 0);
            check("model_failcount", int'(FailCount), m_fail);
        end
    end

    task automatic cyc(input bit b = 0, input bit c = 0, input bit o = 0);
        BtnPulse = b; CheckPassword = c; Logout = o;
        @(posedge clk);
        #1;
        BtnPulse = 0; CheckPassword = 0; Logout = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic fail_attempt();
        cyc(1, 0, 0);
        idle(RW);
    endtask

    initial begin
        rst = 1; BtnPulse = 0; CheckPassword = 0; LoggedIn = 0; Logout = 0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        check("reset_mode", int'(mode), 0);
        check("reset_timeout", int'(timeout), 0);
        check("reset_locked", int'(Locked), 0);
        check("reset_fail", int'(FailCount), 0);
        rst = 0;

        // Happy path
        cyc(0, 1, 0);
        check("happy_pw", int'(mode), 1);
        cyc(1, 0, 0);
        cyc();
        LoggedIn = 1;
        cyc();
        check("happy_session", int'(mode), 2);
        check("happy_no_to", int'(timeout), 0);
        cyc(0, 0, 1);
        check("logout_mode", int'(mode), 0);
        check("logout_to", int'(timeout), 1);
        LoggedIn = 0;
        cyc();
        check("logout_to_one_cycle", int'(timeout), 0);

        // ID inactivity
        cyc(1, 0, 0);
        idle(9);
        check("id_to_early", int'(timeout), 0);
        cyc();
        check("id_to_pulse", int'(timeout), 1);
        check("id_to_mode", int'(mode), 0);
        cyc();
        check("id_to_once", int'(timeout), 0);

        // BtnPulse on the terminal cycle restarts the window
        cyc(1, 0, 0);
        idle(9);
        cyc(1, 0, 0);
        check("btn_beats_to", int'(timeout), 0);
        idle(9);
        check("restart_early", int'(timeout), 0);
        cyc();
        check("restart_to", int'(timeout), 1);

        // Lockout
        cyc(0, 1, 0);
        fail_attempt();
        check("fail1", int'(FailCount), 1);
        check("fail1_mode", int'(mode), 1);
        fail_attempt();
        check("fail2", int'(FailCount), 2);
        fail_attempt();
        check("lock_mode", int'(mode), 3);
        check("lock_flag", int'(Locked), 1);
        check("lock_to", int'(timeout), 1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        cyc(0, 0, 1);
        idle(11);
        check("lock_held", int'(mode), 3);
        cyc();
        check("unlock_mode", int'(mode), 0);
        check("unlock_fail", int'(FailCount), 0);
        check("unlock_flag", int'(Locked), 0);
        check("unlock_no_to", int'(timeout), 0);

        // PW inactivity keeps FailCount
        cyc(0, 1, 0);
        fail_attempt();
        check("pwto_fail1", int'(FailCount), 1);
        idle(9);
        check("pwto_early", int'(mode), 1);
        cyc();
        check("pwto_mode", int'(mode), 0);
        check("pwto_pulse", int'(timeout), 1);
        check("pwto_fail_kept", int'(FailCount), 1);

        // LoggedIn on the result-wait expiry cycle
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        idle(RW - 1);
        LoggedIn = 1;
        cyc();
        check("login_beats_fail", int'(mode), 2);
        check("login_fail_clr", int'(FailCount), 0);

        // Session timeout
        idle(S - 1);
        check("ss_early", int'(mode), 2);
        cyc();
        check("ss_to_mode", int'(mode), 0);
        check("ss_to_pulse", int'(timeout), 1);

        // BtnPulse at cycle 15 defers the session timeout
        LoggedIn = 0;
        cyc(0, 1, 0);
        cyc(1, 0, 0);
        LoggedIn = 1;
        cyc();
        idle(14);
        cyc(1, 0, 0);
        idle(S - 1);
        check("ss_defer_early", int'(mode), 2);
        cyc();
        check("ss_defer_to", int'(timeout), 1);

        // Logout coincident with session expiry
        LoggedIn = 0;
        cyc(0, 1, 0);
        LoggedIn = 1;
        cyc();
        idle(S - 1);
        cyc(0, 0, 1);
        check("lo_to_pulse", int'(timeout), 1);
        cyc();
        check("lo_to_single", int'(timeout), 0);

        // LoggedIn dropping ends the session silently
        LoggedIn = 0;
        cyc(0, 1, 0);
        LoggedIn = 1;
        cyc();
        LoggedIn = 0;
        cyc();
        check("drop_mode", int'(mode), 0);
        check("drop_no_to", int'(timeout), 0);

        // Reset mid-lockout
        cyc(0, 1, 0);
        fail_attempt();
        fail_attempt();
        fail_attempt();
        check("rst_lock_pre", int'(mode), 3);
        idle(3);
        rst = 1;
        cyc();
        rst = 0;
        check("rst_lock_mode", int'(mode), 0);
        check("rst_lock_fail", int'(FailCount), 0);
        check("rst_lock_flag", int'(Locked), 0);
        check("rst_lock_to", int'(timeout), 0);

        // Reset mid-session
        cyc(0, 1, 0);
        LoggedIn = 1;
        cyc();
        idle(5);
        rst = 1;
        cyc();
        rst = 0;
        check("rst_ss_mode", int'(mode), 0);
        check("rst_ss_to", int'(timeout), 0);
        LoggedIn = 0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
